// File: rtl/piso_if.sv
// Handshake bundle for the parallel-in serial-out converter: word-in ready/valid, element-out valid/yumi.
interface piso_if #(
    parameter int unsigned width_p = 1,
    parameter int unsigned depth_p = 8
);
    logic                         valid_i;
    logic [width_p*depth_p-1:0]   data_i;
    logic                         ready_o;
    logic                         valid_o;
    logic [width_p-1:0]           data_o;
    logic                         yumi_i;
    logic                         last_o;

    modport master (
        output valid_i, data_i, yumi_i,
        input  ready_o, valid_o, data_o, last_o
    );

    modport slave (
        input  valid_i, data_i, yumi_i,
        output ready_o, valid_o, data_o, last_o
    );
endinterface

// File: rtl/piso.sv
// Parallel-in, serial-out converter: loads a packed word of depth_p elements and
// emits them one per yumi, with back-to-back reload on the final element.
module piso #(
    parameter int unsigned width_p     = 1,
    parameter int unsigned depth_p     = 8,
    parameter logic        msb_first_p = 1'b0
) (
    input  logic   clk_i,
    input  logic   reset_i,
    piso_if.slave  bus
);
    localparam int unsigned TOT_W = width_p * depth_p;
    localparam int unsigned CNT_W = $clog2(depth_p);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t             r_state, w_state_n;
    logic [CNT_W-1:0]   r_count, w_count_n;
    logic [TOT_W-1:0]   r_shift, w_shift_n;
    logic               w_last;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= IDLE;
            r_count <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_n;
            r_count <= w_count_n;
            r_shift <= w_shift_n;
        end
    end

    // Head element sits at the bottom (LSB-first) or top (MSB-first) of the shift register.
    always_comb begin
        w_last      = (r_state == SHIFT) && (r_count == CNT_W'(depth_p - 1));
        bus.valid_o = (r_state == SHIFT);
        bus.last_o  = w_last;
        bus.ready_o = (r_state == IDLE) | (w_last & bus.yumi_i);
        if (msb_first_p)
            bus.data_o = r_shift[TOT_W-1 -: width_p];
        else
            bus.data_o = r_shift[width_p-1:0];
    end

    always_comb begin
        w_state_n = r_state;
        w_count_n = r_count;
        w_shift_n = r_shift;
        unique case (r_state)
            IDLE: begin
                if (bus.valid_i) begin
                    w_shift_n = bus.data_i;
                    w_count_n = '0;
                    w_state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.yumi_i) begin
                    if (!w_last) begin
                        w_count_n = r_count + CNT_W'(1);
                        if (msb_first_p)
                            w_shift_n = r_shift << width_p;
                        else
                            w_shift_n = r_shift >> width_p;
                    end else if (bus.valid_i) begin
                        w_shift_n = bus.data_i;
                        w_count_n = '0;
                    end else begin
                        // Clear so data_o reads zero while idle, as after reset.
                        w_shift_n = '0;
                        w_count_n = '0;
                        w_state_n = IDLE;
                    end
                end
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase
    end
endmodule

// File: doc/piso.md
Name: piso

Overview:
- Parallel-in, serial-out converter: the transmit-side counterpart of the trickle-in sipo.
- Accepts one packed word of depth_p elements, each width_p bits, over a ready/valid handshake.
- Emits the elements one at a time over a valid/yumi handshake, e.g. a byte driven bit-by-bit onto an LED or pin under button- or divider-paced yumi pulses.
- Back-to-back loading: a new word is accepted in the same cycle the last element of the previous word is consumed.

Parameters:
- width_p, 1, bits per serial element.
- depth_p, 8, elements per packed word; must be >= 2.
- msb_first_p, 1'b0, 0: element 0 = data_i[width_p-1:0] is sent first; 1: element depth_p-1 (top bits) is sent first.

Ports:
- clk_i  input  1  single clock.
- reset_i  input  1  reset, asynchronous and active-high.
- valid_i  input  1  producer has a packed word on data_i.
- data_i  input  width_p*depth_p  packed word.
- ready_o  output  1  block can accept a word this cycle.
- valid_o  output  1  data_o holds a valid element.
- data_o  output  width_p  current element.
- yumi_i  input  1  consumer takes data_o this cycle; legal only while valid_o=1.
- last_o  output  1  data_o is the final element of the current word (qualified by valid_o).

Behaviour:
- Reset (async assert, released synchronously to clk_i):
  - state=IDLE, element counter=0, shift register=0.
  - valid_o=0, ready_o=1, data_o=0, last_o=0.
- States: IDLE, SHIFT.
- IDLE:
  - valid_o=0, ready_o=1.
  - On valid_i: latch data_i into the shift register, count=0, go to SHIFT.
  - valid_o rises the cycle after the load, so latency from accept to first element is 1 cycle.
- SHIFT:
  - valid_o=1; data_o = element at the head of the shift register, ordered per msb_first_p.
  - last_o = (count == depth_p-1).
  - yumi_i=1 with count < depth_p-1: advance shift register by width_p, count+1. data_o changes the next cycle.
  - yumi_i=0: hold data_o, count and state (stall of any length).
  - yumi_i=1 with count == depth_p-1, and valid_i=1: ready_o=1 (combinational from yumi_i), load the new word, count=0, stay in SHIFT. valid_o stays 1 with no bubble.
  - yumi_i=1 with count == depth_p-1, and valid_i=0: go to IDLE; valid_o=0 the next cycle.
- ready_o = (state==IDLE) | (state==SHIFT & last & yumi_i). There is no other path from input to output.
- Handshake rules:
  - Input transfer happens iff valid_i & ready_o.
  - Output transfer happens iff valid_o & yumi_i.
  - yumi_i while valid_o=0 is ignored and does not change state.
  - data_i is sampled only on a transfer; it may change freely otherwise.
- Counter width: $clog2(depth_p). Counter never exceeds depth_p-1 and has no wrap-around beyond the reload.
- Reset mid-word: the partially sent word is discarded and no further elements are emitted.
- The block is purely a forwarder: no arithmetic and no data modification. The concatenation of emitted elements in send order reconstructs data_i exactly.

Test Plan:
- Reset, then idle:
  - Stimulus: width_p=1, depth_p=8, msb_first_p=0; no stimulus after reset.
  - Required: valid_o=0, ready_o=1, data_o=0 both during reset and after release.
- Single word, LSB-first:
  - Stimulus: load 8'hA5, yumi_i held at 1.
  - Required: data_o = 1,0,1,0,0,1,0,1 on 8 consecutive cycles starting 1 cycle after the load; last_o=1 only on the 8th; ready_o=1 only in that 8th cycle; valid_o=0 afterwards.
- Stalls, MSB-first:
  - Stimulus: msb_first_p=1, load 8'hA5, pulse yumi_i once every 3 cycles.
  - Required: sequence 1,0,1,0,0,1,0,1 (MSB first); data_o held stable between pulses; ready_o=0 until the final yumi.
- Back-to-back words:
  - Stimulus: width_p=4, depth_p=2, msb_first_p=0; valid_i held at 1 with 8'h3C then 8'h7E; yumi_i=1.
  - Required: data_o = C,3,E,7 on 4 consecutive cycles; no valid_o bubble; the second word is accepted in the cycle its predecessor's last element is taken.
- Reset mid-word:
  - Stimulus: load 8'hFF, consume 3 bits, assert reset_i between clock edges.
  - Required: valid_o=0 and ready_o=1 immediately, without waiting for an edge; after release, a new load of 8'h01 emits 1,0,0,0,0,0,0,0.
- Spurious yumi:
  - Stimulus: yumi_i=1 while in IDLE for 10 cycles, then load 8'h80.
  - Required: no state change during the 10 cycles; the full 8-bit sequence ending in 1 is then emitted.
